uart_dec_formatter: RTL and testbench
=====================================

# uart_dec_formatter

Upstream feeder for the UART string handler: converts a 32-bit unsigned measurement (for example a frequency count) into a decimal ASCII line, optionally prefixed by a fixed label. It drives the handler's string transmit port (`tx_string`/`tx_length`/`tx_req`) and observes `tx_busy`/`tx_done`. One value is formatted and sent per `start` pulse.

## Interface
- `PREFIX`, default `64'h0`: label ASCII bytes. Byte k is `PREFIX[8k+7:8k]` and is sent k-th.
- `PREFIX_LEN`, default `0`: number of valid label bytes, 0..8.
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `value`  in  32  unsigned number to print; sampled when `start` is accepted.
- `start`  in  1  one-cycle request to format and send `value`.
- `busy`  out  1  high from accept until line completion.
- `done`  out  1  one-cycle pulse when the handler reports the line sent.
- `overrun`  out  1  one-cycle pulse when `start` arrives while `busy`.
- `tx_string`  out  1024  line bytes. Byte k is `tx_string[8k+7:8k]` and is sent k-th. Unused bytes are 0.
- `tx_length`  out  8  number of valid bytes in `tx_string`.
- `tx_req`  out  1  one-cycle send request to the string handler.
- `tx_busy`  in  1  handler busy.
- `tx_done`  in  1  handler one-cycle completion pulse.

## Operation
- Line format: PREFIX bytes, then decimal digits of `value` with leading zeros suppressed, then `8'h0D`, `8'h0A`.
  - `value`=0 prints a single "0".
  - `tx_length` = `PREFIX_LEN` + ndigits + 2, so the range is 3..20.
- FSM states: IDLE, CONV, PACK, REQ, WAIT.
- IDLE
  - `start`=1: latch `value`, clear the BCD register (40 bits, 10 digits), clear `tx_string`, write PREFIX bytes, set write pointer = `PREFIX_LEN`, digit-seen flag = 0.
  - Go to CONV.
- CONV: double dabble, exactly 32 cycles. Each cycle:
  - add 3 to every BCD nibble ≥5;
  - then shift {BCD, value} left by 1.
  - After 32 cycles go to PACK.
- PACK: exactly 10 cycles, digits scanned from most significant (digit 9) to least significant (digit 0). For each digit:
  - if digit≠0, or digit-seen=1, or it is digit 0: write `8'h30`+digit at the pointer, increment the pointer, set digit-seen.
  - On the 10th cycle also write `0D`, `0A` at pointer and pointer+1, set `tx_length` = pointer+2, and go to REQ.
- REQ
  - `tx_busy`=0: assert `tx_req` for one cycle, go to WAIT.
  - `tx_busy`=1: stay in REQ with `tx_req`=0.
- WAIT
  - `tx_done`=1: pulse `done` next cycle, return to IDLE.
  - `tx_string` and `tx_length` stay stable from the end of PACK until after `tx_done`.
- `start` while not in IDLE: ignored, `overrun` pulses next cycle, latched value unchanged.
- `start` in the same cycle as `done`: FSM is already IDLE, so the start is accepted normally.
- A `tx_done` seen outside WAIT is ignored.

## Timing
- Reset (`sys_rst`=1 at an edge):
  - state IDLE;
  - `busy`, `done`, `overrun`, `tx_req` = 0;
  - `tx_string` = 0, `tx_length` = 0;
  - BCD and pointer cleared.
  - Reset mid-operation aborts immediately. No `tx_req` is issued afterward for the aborted value.
- Let `start` be sampled at edge 0:
  - `busy`=1 from edge 0;
  - CONV covers edges 1..32;
  - PACK covers edges 33..42;
  - `tx_req`=1 during the cycle after edge 42, provided `tx_busy`=0.
- Formatting latency from `start` to `tx_req` is 43 cycles minimum, extended 1:1 by cycles with `tx_busy`=1 in REQ.
- `done` and deassertion of `busy` occur the cycle after `tx_done` is sampled in WAIT.
- `tx_req` is never high for more than one consecutive cycle.

## Test plan
- `PREFIX_LEN`=0, `value`=0, handler idle -> `tx_length`=3, bytes 30 0D 0A, `tx_req` 43 cycles after `start`; `done` follows `tx_done`.
- `PREFIX`="F=" (`PREFIX_LEN`=2), `value`=12345 -> bytes "F=12345\r\n", `tx_length`=9, bytes 9..127 zero.
- `value`=32'hFFFFFFFF -> "4294967295\r\n", `tx_length`=12. `value`=1000000 -> "1000000\r\n", confirming interior zeros are kept.
- `tx_busy` held high for 20 cycles at REQ entry -> `tx_req` delayed exactly 20 cycles, single pulse, `tx_string` stable throughout.
- `start` pulsed during CONV and again during WAIT -> two `overrun` pulses, output line unchanged, only one `done`.
- `sys_rst` asserted mid-CONV, then a new `start` with 7 -> all outputs 0 during reset, then the line "7\r\n" only, with no stale `tx_req`.

Source files
------------

// File: rtl/uart_dec_formatter.sv
// uart_dec_formatter
// Formats one 32-bit unsigned value per start pulse into an ASCII line
//   PREFIX bytes, decimal digits (leading zeros suppressed), CR, LF
// and hands it to a UART string handler.
//
// Ports
//   sys_clk, sys_rst     : clock, synchronous active-high reset
//   value, start         : number to print, one-cycle request
//   busy, done, overrun  : status (busy level, done/overrun one-cycle pulses)
//   tx_string, tx_length : line bytes (byte k sent k-th) and byte count
//   tx_req               : one-cycle send request to the handler
//   tx_busy, tx_done     : handler busy level and completion pulse
module uart_dec_formatter #(
  parameter logic [63:0] PREFIX     = 64'h0,
  parameter int          PREFIX_LEN = 0
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [31:0]   value,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic [1023:0] tx_string,
  output logic [7:0]    tx_length,
  output logic          tx_req,
  input  logic          tx_busy,
  input  logic          tx_done
);

  typedef enum logic [2:0] {IDLE, CONV, PACK, REQ, WAIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   value_q, value_d;
  logic [39:0]   bcd_q, bcd_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [7:0]    ptr_q, ptr_d;
  logic          seen_q, seen_d;
  logic [1023:0] str_q, str_d;
  logic [7:0]    len_q, len_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [39:0] add3(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Fresh line buffer holding only the label bytes.
  function automatic logic [1023:0] prefix_line();
    logic [1023:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < PREFIX_LEN) s[k*8 +: 8] = PREFIX[k*8 +: 8];
    end
    return s;
  endfunction

  always_comb begin
    logic [39:0] adj;
    logic [3:0]  digit;
    int          didx;
    int          wp;
    state_d   = state_q;
    value_d   = value_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    seen_d    = seen_q;
    str_d     = str_q;
    len_d     = len_q;
    done_d    = 1'b0;
    overrun_d = start && (state_q != IDLE);
    tx_req    = 1'b0;
    adj       = '0;
    digit     = '0;
    didx      = 0;
    wp        = 0;
    case (state_q)
      IDLE: begin
        if (start) begin
          value_d = value;
          bcd_d   = '0;
          cnt_d   = '0;
          str_d   = prefix_line();
          len_d   = '0;
          ptr_d   = 8'(PREFIX_LEN);
          seen_d  = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        adj     = add3(bcd_q);
        bcd_d   = {adj[38:0], value_q[31]};
        value_d = {value_q[30:0], 1'b0};
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          cnt_d   = '0;
          state_d = PACK;
        end
      end
      PACK: begin
        // cnt 0 scans digit 9 (most significant); digit 0 is always printed.
        didx  = 9 - int'(cnt_q);
        digit = bcd_q[didx*4 +: 4];
        wp    = int'(ptr_q);
        cnt_d = cnt_q + 6'd1;
        if (digit != 4'd0 || seen_q || cnt_q == 6'd9) begin
          str_d[wp*8 +: 8] = 8'h30 + {4'd0, digit};
          ptr_d            = ptr_q + 8'd1;
          seen_d           = 1'b1;
        end
        if (cnt_q == 6'd9) begin
          // Last digit lands at ptr_q, so CR/LF follow it directly.
          str_d[(wp+1)*8 +: 8] = 8'h0D;
          str_d[(wp+2)*8 +: 8] = 8'h0A;
          len_d                = ptr_q + 8'd3;
          ptr_d                = ptr_q + 8'd3;
          cnt_d                = '0;
          state_d              = REQ;
        end
      end
      REQ: begin
        if (!tx_busy) begin
          tx_req  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      value_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      seen_q    <= 1'b0;
      str_q     <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      seen_q    <= seen_d;
      str_q     <= str_d;
      len_q     <= len_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign tx_string = str_q;
  assign tx_length = len_q;

endmodule

// File: tb/tb_uart_dec_formatter.sv
module tb_uart_dec_formatter;

  localparam logic [63:0] PFX = 64'h3D46; // "F=" : 'F' is byte 0

  logic          sys_clk = 1'b0;
  logic          sys_rst, start, tx_busy, tx_done;
  logic [31:0]   value;
  logic          busy0, done0, ovr0, req0;
  logic          busy1, done1, ovr1, req1;
  logic [1023:0] str0, str1;
  logic [7:0]    len0, len1;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  uart_dec_formatter #(.PREFIX(64'h0), .PREFIX_LEN(0)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .value(value), .start(start),
    .busy(busy0), .done(done0), .overrun(ovr0), .tx_string(str0),
    .tx_length(len0), .tx_req(req0), .tx_busy(tx_busy), .tx_done(tx_done));

  uart_dec_formatter #(.PREFIX(PFX), .PREFIX_LEN(2)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .value(value), .start(start),
    .busy(busy1), .done(done1), .overrun(ovr1), .tx_string(str1),
    .tx_length(len1), .tx_req(req1), .tx_busy(tx_busy), .tx_done(tx_done));

  typedef struct {
    logic [31:0] val;
    string       digits;
    int          busy_cyc;
    bit          ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got low bytes %h expected %h", name, act[191:0], exp[191:0]);
    end
  endtask

  function automatic logic [1023:0] build(input int plen, input string d);
    logic [1023:0] v;
    int p;
    v = '0;
    p = 0;
    for (int k = 0; k < plen; k++) begin
      v[p*8 +: 8] = PFX[k*8 +: 8];
      p++;
    end
    for (int i = 0; i < d.len(); i++) begin
      v[p*8 +: 8] = d[i];
      p++;
    end
    v[p*8 +: 8]     = 8'h0D;
    v[(p+1)*8 +: 8] = 8'h0A;
    return v;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},    {busy0, busy1}, 2'b00);
    chk({tag, "_done"},    {done0, done1}, 2'b00);
    chk({tag, "_overrun"}, {ovr0, ovr1},   2'b00);
    chk({tag, "_tx_req"},  {req0, req1},   2'b00);
    chk({tag, "_len"},     {len0, len1},   16'h0);
    chk_str({tag, "_str0"}, str0, '0);
    chk_str({tag, "_str1"}, str1, '0);
  endtask

  task automatic run_line(input logic [31:0] v, input string d, input int bc, input bit ovr);
    int n, ovr_cnt, dones;
    bit stable;
    logic [1023:0] snap, e0, e1;
    e0 = build(0, d);
    e1 = build(2, d);
    snap = '0;
    @(negedge sys_clk);
    value = v;
    start = 1'b1;
    #1;
    n = 0;
    ovr_cnt = 0;
    stable = 1'b1;
    while (1) begin
      @(negedge sys_clk);
      n++;
      start = ovr && (n == 10);
      if (start) value = 32'd55555;
      tx_busy = (n >= 43) && (n < 43 + bc);
      #1;
      ovr_cnt += int'(ovr0);
      if (n == 1) chk("busy_after_accept", busy0, 1);
      if (n == 43) snap = str0;
      if (n > 43 && str0 !== snap) stable = 1'b0;
      if (req0 || n >= 200) break;
    end
    chk($sformatf("req_latency_%0d", v), n, 43 + bc);
    chk("req_dut1", req1, 1);
    chk_str($sformatf("line0_%0d", v), str0, e0);
    chk_str($sformatf("line1_%0d", v), str1, e1);
    chk("len0", len0, d.len() + 2);
    chk("len1", len1, d.len() + 4);
    if (bc > 0) chk("str_stable_req", stable, 1);
    dones = 0;
    for (int w = 1; w <= 6; w++) begin
      @(negedge sys_clk);
      start   = ovr && (w == 1);
      tx_done = (w == 4);
      tx_busy = (w <= 3);
      #1;
      ovr_cnt += int'(ovr0);
      dones   += int'(done0);
      if (w == 1) chk("req_single", req0, 0);
      if (w == 3) chk("busy_in_wait", busy0, 1);
      if (w == 4) chk_str("str_stable_wait", str0, e0);
      if (w == 5) begin
        chk("done_pulse", {done0, done1}, 2'b11);
        chk("busy_cleared", {busy0, busy1}, 2'b00);
      end
    end
    chk("done_count", dones, 1);
    chk("overrun_count", ovr_cnt, ovr ? 2 : 0);
  endtask

  initial begin
    int stale;
    vecs[0] = '{32'd0,          "0",          0,  1'b0};
    vecs[1] = '{32'd12345,      "12345",      0,  1'b0};
    vecs[2] = '{32'hFFFFFFFF,   "4294967295", 0,  1'b0};
    vecs[3] = '{32'd1000000,    "1000000",    0,  1'b0};
    vecs[4] = '{32'd987654321,  "987654321",  20, 1'b0};
    vecs[5] = '{32'd100,        "100",        0,  1'b1};

    sys_rst = 1'b1;
    start   = 1'b0;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    value   = '0;
    repeat (3) @(negedge sys_clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge sys_clk);
    sys_rst = 1'b0;

    foreach (vecs[i]) run_line(vecs[i].val, vecs[i].digits, vecs[i].busy_cyc, vecs[i].ovr);

    // Reset in the middle of a conversion.
    @(negedge sys_clk);
    value = 32'hDEAD;
    start = 1'b1;
    repeat (10) begin
      @(negedge sys_clk);
      start = 1'b0;
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    #1;
    chk_idle_outputs("midreset");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    stale = 0;
    repeat (60) begin
      @(negedge sys_clk);
      #1;
      stale += int'(req0) + int'(req1) + int'(busy0);
    end
    chk("no_stale_req", stale, 0);
    run_line(32'd7, "7", 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
